// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the multicycle MIPS register-read path.
//   DATA_W      register and datapath width in bits
//   REG_ADDR_W  register index width (fixed at 5)
//   REG_ZERO    hard-wired zero register
//   REG_SP      stack-pointer register index
//   REG_RA      return-address (link) register index
//   SP_RESET    value loaded into the stack pointer at reset
//   rdst_t      operand-read FSM state
package cpu_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_ZERO   = 0;
    localparam int REG_SP     = 29;
    localparam int REG_RA     = 31;
    localparam int SP_RESET   = 227;

    typedef enum logic {
        IDLE = 1'b0,
        RD   = 1'b1
    } rdst_t;

endpackage

// File: rtl/reg_bank_rd_if.sv
// reg_bank_rd_if
// Bundles the write-back and operand-read signals of the register bank.
//   reg_write  write enable for the bank
//   wreg_addr  destination register index
//   wdata      write-back data
//   rd_req     operand read request
//   rs_addr    source register A index
//   rt_addr    source register B index
//   a_out      registered operand A
//   b_out      registered operand B
//   rd_valid   one-cycle pulse after each accepted read
//   busy       high while a read is being presented
// Modports: master drives requests (decode side), slave is the bank.
interface reg_bank_rd_if;
    import cpu_pkg::*;

    logic                  reg_write;
    logic [REG_ADDR_W-1:0] wreg_addr;
    logic [DATA_W-1:0]     wdata;
    logic                  rd_req;
    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0]     a_out;
    logic [DATA_W-1:0]     b_out;
    logic                  rd_valid;
    logic                  busy;

    modport master (
        output reg_write, wreg_addr, wdata, rd_req, rs_addr, rt_addr,
        input  a_out, b_out, rd_valid, busy
    );

    modport slave (
        input  reg_write, wreg_addr, wdata, rd_req, rs_addr, rt_addr,
        output a_out, b_out, rd_valid, busy
    );

endinterface

// File: rtl/reg_fwd_sel.sv
// reg_fwd_sel
// Per-port operand select: passes the stored register value, or the
// write-back data when the same register is being written on this edge
// and forwarding is enabled.
//   en         forwarding enable (tied off when forwarding is not built)
//   reg_write  write enable of the bank
//   wreg_addr  register being written
//   wdata      write-back data
//   rd_addr    register being read by this port
//   reg_data   stored value of reg[rd_addr]
//   sel_data   value this port should latch
module reg_fwd_sel
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DATA_W
) (
    input  logic                  en,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] wreg_addr,
    input  logic [DW-1:0]         wdata,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [DW-1:0]         reg_data,
    output logic [DW-1:0]         sel_data
);

    logic hit;

    // Register 0 is never written, so a write to it must not forward either.
    assign hit = en && reg_write
                 && (wreg_addr != REG_ADDR_W'(REG_ZERO))
                 && (wreg_addr == rd_addr);

    assign sel_data = hit ? wdata : reg_data;

endmodule

// File: rtl/reg_bank_rd.sv
// reg_bank_rd
// 32x32 general-purpose register bank with registered rs/rt operand reads
// behind a request/valid handshake.
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous, active-high; clears the bank (SP loads SP_INIT),
//          the operand registers and the FSM
//   bus    reg_bank_rd_if.slave: write port, read request and operands
// Optional build macro REG_BANK_BYPASS_EN: when defined, a read of a
// register being written on the same edge latches the new write data;
// otherwise it latches the pre-write contents.
module reg_bank_rd #(
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int NREG    = 32,
    parameter int SP_REG  = cpu_pkg::REG_SP,
    parameter int SP_INIT = cpu_pkg::SP_RESET,
    parameter int RA_REG  = cpu_pkg::REG_RA
) (
    input  logic          clk,
    input  logic          reset,
    reg_bank_rd_if.slave  bus
);
    import cpu_pkg::*;

    // The index width is fixed, so every special register must be addressable.
    if (SP_REG >= NREG || RA_REG >= NREG || NREG > (1 << REG_ADDR_W)) begin : g_bad_cfg
        $error("reg_bank_rd: register index parameters out of range");
    end

`ifdef REG_BANK_BYPASS_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    logic [DATA_W-1:0] bank [NREG];
    logic [DATA_W-1:0] bank_a;
    logic [DATA_W-1:0] bank_b;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    rdst_t             state;
    rdst_t             next_state;

    // Register bank; reset wins over a concurrent write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                bank[i] <= (i == SP_REG) ? DATA_W'(SP_INIT) : '0;
            end
        end else if (bus.reg_write && bus.wreg_addr != REG_ADDR_W'(REG_ZERO)) begin
            bank[bus.wreg_addr] <= bus.wdata;
        end
    end

    // Register 0 is forced to zero on read rather than relying on its storage.
    assign bank_a = (bus.rs_addr == REG_ADDR_W'(REG_ZERO)) ? '0 : bank[bus.rs_addr];
    assign bank_b = (bus.rt_addr == REG_ADDR_W'(REG_ZERO)) ? '0 : bank[bus.rt_addr];

    reg_fwd_sel #(.DW(DATA_W)) u_fwd_a (
        .en        (FWD_EN),
        .reg_write (bus.reg_write),
        .wreg_addr (bus.wreg_addr),
        .wdata     (bus.wdata),
        .rd_addr   (bus.rs_addr),
        .reg_data  (bank_a),
        .sel_data  (sel_a)
    );

    reg_fwd_sel #(.DW(DATA_W)) u_fwd_b (
        .en        (FWD_EN),
        .reg_write (bus.reg_write),
        .wreg_addr (bus.wreg_addr),
        .wdata     (bus.wdata),
        .rd_addr   (bus.rt_addr),
        .reg_data  (bank_b),
        .sel_data  (sel_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A request is accepted in either state, so back-to-back reads keep RD.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = bus.rd_req ? RD : IDLE;
            RD:      next_state = bus.rd_req ? RD : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.rd_valid = 1'b0;
        bus.busy     = 1'b0;
        if (state == RD) begin
            bus.rd_valid = 1'b1;
            bus.busy     = 1'b1;
        end
    end

    // Operands hold their last value until the next accepted request.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.a_out <= '0;
            bus.b_out <= '0;
        end else if (bus.rd_req) begin
            bus.a_out <= sel_a;
            bus.b_out <= sel_b;
        end
    end

endmodule

// File: tb/tb_reg_bank_rd.sv
// tb_reg_bank_rd
// Self-checking bench for reg_bank_rd: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the register file and read handshake.
// Honours REG_BANK_BYPASS_EN to select the expected collision behaviour.
module tb_reg_bank_rd;

    logic clk;
    logic reset;

    reg_bank_rd_if bus ();

    reg_bank_rd dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nChecks = 0;
    int nFails  = 0;
    bit tbDone  = 1'b0;

    // Behavioural model: an array of registers plus the last latched operands.
    logic [31:0] mRegs [32];
    logic [31:0] mA, mB, mRa, mRb;
    logic        mValid;
    bit          mLive = 1'b0;

`ifdef REG_BANK_BYPASS_EN
    localparam logic [31:0] COLLIDE_EXP = 32'h40;
`else
    localparam logic [31:0] COLLIDE_EXP = 32'h0;
`endif

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic req,
                                 input logic [4:0] rs, input logic [4:0] rt);
        reset         = rst;
        bus.reg_write = we;
        bus.wreg_addr = wa;
        bus.wdata     = wd;
        bus.rd_req    = req;
        bus.rs_addr   = rs;
        bus.rt_addr   = rt;
        @(negedge clk);
    endtask

    // Model update on each rising edge from the inputs that edge samples.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mRegs[i] = 32'h0;
            mRegs[29] = 32'd227;
            mA        = 32'h0;
            mB        = 32'h0;
            mValid    = 1'b0;
            mLive     = 1'b1;
        end else begin
            mRa = (bus.rs_addr == 5'd0) ? 32'h0 : mRegs[bus.rs_addr];
            mRb = (bus.rt_addr == 5'd0) ? 32'h0 : mRegs[bus.rt_addr];
`ifdef REG_BANK_BYPASS_EN
            if (bus.reg_write && bus.wreg_addr != 5'd0) begin
                if (bus.wreg_addr == bus.rs_addr) mRa = bus.wdata;
                if (bus.wreg_addr == bus.rt_addr) mRb = bus.wdata;
            end
`endif
            if (bus.rd_req) begin
                mA = mRa;
                mB = mRb;
            end
            mValid = bus.rd_req;
            if (bus.reg_write && bus.wreg_addr != 5'd0) mRegs[bus.wreg_addr] = bus.wdata;
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (mLive && !tbDone) begin
            checkOutput("a_out", bus.a_out, mA);
            checkOutput("b_out", bus.b_out, mB);
            checkOutput("rd_valid", {31'h0, bus.rd_valid}, {31'h0, mValid});
            checkOutput("busy", {31'h0, bus.busy}, {31'h0, mValid});
        end
    end

    initial begin
        logic        rst, we, req;
        logic [4:0]  wa, rs, rt;
        logic [31:0] wd;

        $display("[TB] reg_bank_rd bench starting");

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_valid", {31'h0, bus.rd_valid}, 32'h0);
        checkOutput("reset_busy", {31'h0, bus.busy}, 32'h0);
        checkOutput("reset_a", bus.a_out, 32'h0);
        checkOutput("model_sp_reset", mRegs[29], 32'd227);

        // Stack pointer comes out of reset at 227.
        applyStimulus(0, 0, 0, 0, 1, 29, 0);
        checkOutput("sp_read_valid", {31'h0, bus.rd_valid}, 32'h1);
        checkOutput("sp_read_busy", {31'h0, bus.busy}, 32'h1);
        checkOutput("sp_read_a", bus.a_out, 32'd227);
        checkOutput("sp_read_b", bus.b_out, 32'h0);
        checkOutput("model_sp_read_a", mA, 32'd227);

        // Writes to reg 8 and (discarded) reg 0.
        applyStimulus(0, 1, 8, 32'hDEADBEEF, 0, 0, 0);
        checkOutput("idle_valid", {31'h0, bus.rd_valid}, 32'h0);
        checkOutput("hold_a", bus.a_out, 32'd227);
        applyStimulus(0, 1, 0, 32'd5, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 8, 0);
        checkOutput("r8_a", bus.a_out, 32'hDEADBEEF);
        checkOutput("r0_b", bus.b_out, 32'h0);
        applyStimulus(0, 0, 0, 0, 1, 8, 8);
        checkOutput("same_idx_a", bus.a_out, 32'hDEADBEEF);
        checkOutput("same_idx_b", bus.b_out, 32'hDEADBEEF);

        // Same-edge write and read of reg 31.
        applyStimulus(0, 1, 31, 32'h40, 1, 31, 0);
        checkOutput("collide_a", bus.a_out, COLLIDE_EXP);
        checkOutput("model_collide_a", mA, COLLIDE_EXP);
        applyStimulus(0, 0, 0, 0, 1, 31, 0);
        checkOutput("after_collide_a", bus.a_out, 32'h40);

        // Back-to-back reads of preloaded regs 1..3.
        applyStimulus(0, 1, 1, 32'd10, 0, 0, 0);
        applyStimulus(0, 1, 2, 32'd20, 0, 0, 0);
        applyStimulus(0, 1, 3, 32'd30, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 5'(i), 0);
            checkOutput("b2b_valid", {31'h0, bus.rd_valid}, 32'h1);
            checkOutput("b2b_a", bus.a_out, 32'(10 * i));
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("b2b_end_valid", {31'h0, bus.rd_valid}, 32'h0);
        checkOutput("b2b_end_a", bus.a_out, 32'd30);

        // Reset while in RD, with a concurrent write that must be dropped.
        applyStimulus(0, 0, 0, 0, 1, 1, 2);
        applyStimulus(1, 1, 29, 32'd7, 1, 29, 0);
        checkOutput("midrst_valid", {31'h0, bus.rd_valid}, 32'h0);
        checkOutput("midrst_a", bus.a_out, 32'h0);
        applyStimulus(0, 0, 0, 0, 1, 29, 0);
        checkOutput("midrst_sp", bus.a_out, 32'd227);

        // Randomized traffic, biased towards low indices and collisions.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 79) == 0);
            we  = $urandom_range(0, 1) == 1;
            req = $urandom_range(0, 2) != 0;
            rs  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            rt  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0:       wa = rs;
                1:       wa = rt;
                default: wa = 5'($urandom_range(0, 31));
            endcase
            wd = $urandom;
            applyStimulus(rst, we, wa, wd, req, rs, rt);
        end

        tbDone = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
